vga_sync_gen: RTL

VGA 640x480 @ 60 Hz timing generator, clocked by the 25 MHz pixel clock from the clock-divider stage. Produces active-low hsync/vsync, a visible-area flag, the current pixel coordinates and per-line/per-frame strobes. Downstream pixel-colour logic consumes these outputs. All outputs are registered and mutually aligned, so every output describes the same pixel in the same cycle.

---
 rtl/vga_sync_gen_if.sv | 22 ++
 rtl/vga_sync_gen.sv | 97 +++++++++
 2 files changed

// File: rtl/vga_sync_gen_if.sv
// Output bundle of the VGA timing generator: sync pulses, visible flag,
// pixel coordinates, line/frame strobes and the frame counter.
interface vga_sync_gen_if;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_cnt;

  modport master (
    output hsync, vsync, video_on, pixel_x, pixel_y,
           line_start, frame_start, frame_cnt
  );

  modport slave (
    input  hsync, vsync, video_on, pixel_x, pixel_y,
           line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing generator (640x480 @ 60 Hz by default). Every output is a
// register loaded from the next-state counter values, so coordinates and
// their decoded flags always change on the same edge.
// H_TOTAL and V_TOTAL must each be <= 1024 (10-bit counters).
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);

  // Decode bounds are 11 bits wide so an end bound equal to 1024 still fits.
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0]  x_q, y_q;
  logic [9:0]  x_nxt, y_nxt;
  logic [10:0] x_nxt_w, y_nxt_w;
  logic        x_wrap, frame_wrap;

  logic        hsync_q, vsync_q, video_on_q;
  logic        line_start_q, frame_start_q;
  logic [7:0]  frame_cnt_q;

  // Next-state counters: wrap detected by compare against TOTAL-1.
  always_comb begin
    x_wrap     = (x_q == H_MAX);
    frame_wrap = x_wrap && (y_q == V_MAX);
    x_nxt      = x_wrap ? 10'd0 : x_q + 10'd1;
    y_nxt      = y_q;
    if (x_wrap) begin
      y_nxt = (y_q == V_MAX) ? 10'd0 : y_q + 10'd1;
    end
    x_nxt_w = {1'b0, x_nxt};
    y_nxt_w = {1'b0, y_nxt};
  end

  // Counter registers; reset parks on the last pixel of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= H_MAX;
      y_q <= V_MAX;
    end else begin
      x_q <= x_nxt;
      y_q <= y_nxt;
    end
  end

  // Decoded outputs registered from the next-state counters (zero skew).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      hsync_q       <= !((x_nxt_w >= HS_START) && (x_nxt_w < HS_END));
      vsync_q       <= !((y_nxt_w >= VS_START) && (y_nxt_w < VS_END));
      video_on_q    <= (x_nxt_w < H_VIS) && (y_nxt_w < V_VIS);
      line_start_q  <= x_wrap;
      frame_start_q <= frame_wrap;
      if (frame_wrap) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  assign vga.pixel_x     = x_q;
  assign vga.pixel_y     = y_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_on_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_cnt   = frame_cnt_q;

endmodule
